// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM controller: controller state encoding,
// address field widths, default timing values and the address-splitting
// helpers used by the controller. No ports (package only).
package dram_pkg;

   localparam int ROW_W      = 11;
   localparam int COL_W      = 10;
   localparam int ADDR_W_DEF = ROW_W + COL_W;

   // Default DRAM timing, in core clock cycles.
   localparam int T_RCD_DEF = 3;
   localparam int T_CL_DEF  = 5;
   localparam int T_RP_DEF  = 3;
   localparam int T_WR_DEF  = 2;

   typedef enum logic [2:0] {
      IDLE,
      ACT,
      RCD,
      CAS,
      CL_WAIT,
      WR_HOLD,
      PRE,
      RESP
   } dram_state_e;

   function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W_DEF-1:0] addr);
      return addr[ADDR_W_DEF-1:COL_W];
   endfunction

   function automatic logic [COL_W-1:0] col_of(input logic [ADDR_W_DEF-1:0] addr);
      return addr[COL_W-1:0];
   endfunction

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/dram_wait_cnt.sv
// Loadable down-counter shared by all timed controller states.
// Ports:
//   clk, rst_n    core clock, asynchronous active-low reset
//   load_i        load load_val_i this cycle (state entry)
//   load_val_i    number of additional cycles to wait after the entry cycle
//   done_o        counter has reached zero
module dram_wait_cnt #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/dram_ctrl.sv
// Memory-side DRAM controller: turns single-word read/write requests into
// RAS/CAS command sequences, keeps the last row open for page hits and
// returns read data / write completion as a one-cycle response pulse.
// Ports:
//   clk, rst                     core clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_addr/req_wstrb/req_wdata word address, byte enables (0 = read), data
//   resp_valid/resp_rdata        response pulse and read data
//   DRAM_*                       external DRAM pins (strobes active low)
//   err                          sticky flag: a read never saw DRAM_valid
module dram_ctrl
   import dram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int T_RCD  = T_RCD_DEF,
   parameter int T_CL   = T_CL_DEF,
   parameter int T_RP   = T_RP_DEF,
   parameter int T_WR   = T_WR_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [3:0]        req_wstrb,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              DRAM_CSn,
   output logic [3:0]        DRAM_WEn,
   output logic              DRAM_RASn,
   output logic              DRAM_CASn,
   output logic [ROW_W-1:0]  DRAM_A,
   output logic [31:0]       DRAM_D,
   input  logic [31:0]       DRAM_Q,
   input  logic              DRAM_valid,
   output logic              err
);

   localparam int CNT_W = $clog2(max4(T_RCD, T_CL, T_RP, T_WR) + 4);

   // Reload values: the entry cycle counts as the first cycle of the state.
   localparam logic [CNT_W-1:0] LD_PRE = CNT_W'(T_RP - 1);
   localparam logic [CNT_W-1:0] LD_RCD = CNT_W'((T_RCD > 1) ? T_RCD - 2 : 0);
   localparam logic [CNT_W-1:0] LD_CL  = CNT_W'(T_CL + 3);
   localparam logic [CNT_W-1:0] LD_WR  = CNT_W'((T_WR > 1) ? T_WR - 2 : 0);

   dram_state_e        state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [3:0]         wstrb_q, wstrb_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [ROW_W-1:0]   open_row_q, open_row_d;
   logic               open_row_valid_q, open_row_valid_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               err_q, err_d;

   logic               cnt_load;
   logic [CNT_W-1:0]   cnt_val;
   logic               cnt_done;

   dram_wait_cnt #(.CNT_W(CNT_W)) u_wait_cnt (
      .clk        (clk),
      .rst_n      (rst),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .done_o     (cnt_done)
   );

   // Next-state logic.
   // NOTE: every variable gets a default at the top of always_comb so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d          = state_q;
      addr_d           = addr_q;
      wstrb_d          = wstrb_q;
      wdata_d          = wdata_q;
      open_row_d       = open_row_q;
      open_row_valid_d = open_row_valid_q;
      rdata_d          = rdata_q;
      err_d            = err_q;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               wstrb_d = req_wstrb;
               wdata_d = req_wdata;
               if (!open_row_valid_q)                      state_d = ACT;
               else if (row_of(req_addr) == open_row_q)    state_d = CAS;
               else                                        state_d = PRE;
            end
         end
         PRE: begin
            open_row_valid_d = 1'b0;
            if (cnt_done) state_d = ACT;
         end
         ACT: begin
            open_row_valid_d = 1'b1;
            open_row_d       = row_of(addr_q);
            state_d          = (T_RCD > 1) ? RCD : CAS;
         end
         RCD: begin
            if (cnt_done) state_d = CAS;
         end
         CAS: begin
            if (wstrb_q == 4'h0) state_d = CL_WAIT;
            else                 state_d = (T_WR > 1) ? WR_HOLD : RESP;
         end
         CL_WAIT: begin
            // Real data wins over a timeout expiring in the same cycle.
            if (DRAM_valid) begin
               rdata_d = DRAM_Q;
               state_d = RESP;
            end else if (cnt_done) begin
               rdata_d = 32'hDEAD_BEEF;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         WR_HOLD: begin
            if (cnt_done) state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The shared wait counter restarts whenever the FSM changes state.
   always_comb begin
      cnt_load = (state_d != state_q);
      unique case (state_d)
         PRE:     cnt_val = LD_PRE;
         RCD:     cnt_val = LD_RCD;
         CL_WAIT: cnt_val = LD_CL;
         WR_HOLD: cnt_val = LD_WR;
         default: cnt_val = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= IDLE;
         addr_q           <= '0;
         wstrb_q          <= '0;
         wdata_q          <= '0;
         open_row_q       <= '0;
         open_row_valid_q <= 1'b0;
         rdata_q          <= '0;
         err_q            <= 1'b0;
      end else begin
         state_q          <= state_d;
         addr_q           <= addr_d;
         wstrb_q          <= wstrb_d;
         wdata_q          <= wdata_d;
         open_row_q       <= open_row_d;
         open_row_valid_q <= open_row_valid_d;
         rdata_q          <= rdata_d;
         err_q            <= err_d;
      end
   end

   // Pin decode: Moore outputs from registered state only. RASn stays low
   // whenever a row is open, so the page survives across IDLE and RESP.
   always_comb begin
      DRAM_WEn  = 4'hF;
      DRAM_RASn = ~open_row_valid_q;
      DRAM_CASn = 1'b1;
      DRAM_A    = '0;
      DRAM_D    = '0;
      unique case (state_q)
         PRE: begin
            DRAM_RASn = 1'b1;
            DRAM_WEn  = 4'h0;
         end
         ACT: begin
            DRAM_RASn = 1'b0;
            DRAM_A    = row_of(addr_q);
         end
         CAS, CL_WAIT, WR_HOLD: begin
            DRAM_CASn = 1'b0;
            DRAM_A    = {1'b0, col_of(addr_q)};
            if (wstrb_q != 4'h0) begin
               DRAM_WEn = ~wstrb_q;
               DRAM_D   = wdata_q;
            end
         end
         default: ;
      endcase
   end

   assign DRAM_CSn   = 1'b0;
   // Gated with rst so ready reads low while reset is held.
   assign req_ready  = rst && (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rdata_q;
   assign err        = err_q;

endmodule
